// File: rtl/r16b_xfer_assert_if.sv
// Bus bundle for r16b_xfer_assert: register input, active-low asserts, and
// the registered transfer/main bus outputs.
// Optional feature macro: R16B_XFER_ASSERT_LOFIRST_EN adds lo_first.
interface r16b_xfer_assert_if;
  logic [15:0] RegIn;
  logic        xfer_assert;
  logic        main_split_req;
  logic        main_high_assert;
  logic        main_low_assert;
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
  logic        lo_first;
`endif
  logic [15:0] XferBusOut;
  logic        XferBusOE;
  logic [7:0]  MainBusOut;
  logic        MainBusOE;
  logic        busy;
  logic        done;

  // Driver side: register value and control strobes.
  modport master (
    output RegIn, xfer_assert, main_split_req, main_high_assert, main_low_assert,
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
    output lo_first,
`endif
    input  XferBusOut, XferBusOE, MainBusOut, MainBusOE, busy, done
  );

  // Asserter side: consumes controls, drives both buses.
  modport slave (
    input  RegIn, xfer_assert, main_split_req, main_high_assert, main_low_assert,
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
    input  lo_first,
`endif
    output XferBusOut, XferBusOE, MainBusOut, MainBusOE, busy, done
  );
endinterface

// File: rtl/r16b_xfer_assert.sv
// Asserts a 16-bit register value onto the 16-bit transfer bus and/or the
// 8-bit main bus (single byte, or snapshotted high-then-low split with an
// optional idle gap). All bus outputs are registered.
// Optional feature macro: R16B_XFER_ASSERT_LOFIRST_EN (lo_first byte swap).
module r16b_xfer_assert #(
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic                  clk,
  input logic                  rst,
  r16b_xfer_assert_if.slave    bus
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? CNT_W'(0) : CNT_W'(GAP_CYCLES - 1);

  // Elaboration-time range check on the gap length.
  if (GAP_CYCLES > 3) begin : g_gap_range_check
    $error("r16b_xfer_assert: GAP_CYCLES must be in 0..3");
  end

  typedef enum logic [1:0] {IDLE, HIGH, GAP, LOW} state_e;

  state_e           state_q;
  logic [15:0]      shadow_q;
  logic [15:0]      shadow_d;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [15:0]      xfer_out_q;
  logic             xfer_oe_q;
  logic [7:0]       main_out_q;
  logic             main_oe_q;
  logic             busy_q;
  logic             done_q;

  // Snapshot to capture on a split start; stored in slot order (first byte high).
  always_comb begin
    shadow_d = bus.RegIn;
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
    if (bus.lo_first) begin
      shadow_d = {bus.RegIn[7:0], bus.RegIn[15:8]};
    end
`endif
  end

  // Transfer path plus main-bus split state machine, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= 16'd0;
      gap_cnt_q  <= '0;
      xfer_out_q <= 16'd0;
      xfer_oe_q  <= 1'b0;
      main_out_q <= 8'd0;
      main_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (!bus.xfer_assert) begin
        xfer_out_q <= bus.RegIn;
        xfer_oe_q  <= 1'b1;
      end else begin
        xfer_oe_q  <= 1'b0;
      end

      case (state_q)
        HIGH: begin
          if (GAP_CYCLES == 0) begin
            state_q    <= LOW;
            main_out_q <= shadow_q[7:0];
            main_oe_q  <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            state_q    <= GAP;
            main_oe_q  <= 1'b0;
            gap_cnt_q  <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) begin
            state_q    <= LOW;
            main_out_q <= shadow_q[7:0];
            main_oe_q  <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            gap_cnt_q  <= gap_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // IDLE and LOW share the same decision: restart a split or apply single-byte rules.
          done_q <= 1'b0;
          if (!bus.main_split_req) begin
            state_q    <= HIGH;
            shadow_q   <= shadow_d;
            main_out_q <= shadow_d[15:8];
            main_oe_q  <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!bus.main_high_assert) begin
              main_out_q <= bus.RegIn[15:8];
              main_oe_q  <= 1'b1;
            end else if (!bus.main_low_assert) begin
              main_out_q <= bus.RegIn[7:0];
              main_oe_q  <= 1'b1;
            end else begin
              main_oe_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.XferBusOut = xfer_out_q;
  assign bus.XferBusOE  = xfer_oe_q;
  assign bus.MainBusOut = main_out_q;
  assign bus.MainBusOE  = main_oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_r16b_xfer_assert.sv
// Bench for r16b_xfer_assert: two instances (GAP_CYCLES 0 and 2) share one
// stimulus stream; a slot-schedule model predicts every output each cycle.
module tb_r16b_xfer_assert;

  localparam int unsigned G0 = 0;
  localparam int unsigned G1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst;
  logic [15:0] t_regin;
  logic        t_xa, t_split, t_ha, t_la, t_lo;

  r16b_xfer_assert_if bus0 ();
  r16b_xfer_assert_if bus1 ();

  assign bus0.RegIn = t_regin;            assign bus1.RegIn = t_regin;
  assign bus0.xfer_assert = t_xa;         assign bus1.xfer_assert = t_xa;
  assign bus0.main_split_req = t_split;   assign bus1.main_split_req = t_split;
  assign bus0.main_high_assert = t_ha;    assign bus1.main_high_assert = t_ha;
  assign bus0.main_low_assert = t_la;     assign bus1.main_low_assert = t_la;
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
  assign bus0.lo_first = t_lo;            assign bus1.lo_first = t_lo;
`endif

  r16b_xfer_assert #(.GAP_CYCLES(G0)) u_dut0 (.clk(clk), .rst(t_rst), .bus(bus0));
  r16b_xfer_assert #(.GAP_CYCLES(G1)) u_dut1 (.clk(clk), .rst(t_rst), .bus(bus1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pos = slot index within an active split (-1 when not splitting).
  int          m_pos  [2];
  logic [15:0] m_snap [2];
  logic [15:0] m_xout [2];
  logic        m_xoe  [2];
  logic [7:0]  m_mout [2];
  logic        m_moe  [2];
  logic        m_busy [2];
  logic        m_done [2];

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? int'(G0) : int'(G1);
  endfunction

  // Split of gap g occupies g+2 slots: first byte, g silent slots, second byte with done.
  task automatic model_slot(input int i);
    int g;
    g = gap_of(i);
    m_busy[i] = 1'b1;
    m_done[i] = 1'b0;
    if (m_pos[i] == 0) begin
      m_moe[i] = 1'b1; m_mout[i] = m_snap[i][15:8];
    end else if (m_pos[i] == g + 1) begin
      m_moe[i] = 1'b1; m_mout[i] = m_snap[i][7:0]; m_done[i] = 1'b1;
    end else begin
      m_moe[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i);
    if (t_rst) begin
      m_pos[i] = -1; m_snap[i] = 16'd0;
      m_xout[i] = 16'd0; m_xoe[i] = 1'b0; m_mout[i] = 8'd0; m_moe[i] = 1'b0;
      m_busy[i] = 1'b0; m_done[i] = 1'b0;
      return;
    end
    if (!t_xa) begin m_xout[i] = t_regin; m_xoe[i] = 1'b1; end
    else m_xoe[i] = 1'b0;
    if (m_pos[i] >= 0 && m_pos[i] < gap_of(i) + 1) begin
      m_pos[i]++;
      model_slot(i);
    end else if (!t_split) begin
      m_snap[i] = t_regin;
`ifdef R16B_XFER_ASSERT_LOFIRST_EN
      if (t_lo) m_snap[i] = {t_regin[7:0], t_regin[15:8]};
`endif
      m_pos[i] = 0;
      model_slot(i);
    end else begin
      m_pos[i] = -1; m_busy[i] = 1'b0; m_done[i] = 1'b0;
      if (!t_ha) begin m_moe[i] = 1'b1; m_mout[i] = t_regin[15:8]; end
      else if (!t_la) begin m_moe[i] = 1'b1; m_mout[i] = t_regin[7:0]; end
      else m_moe[i] = 1'b0;
    end
  endtask

  task automatic check_inst(input int i, input logic [15:0] xo, input logic xe,
                            input logic [7:0] mo, input logic me, input logic bz, input logic dn);
    string p;
    p = $sformatf("gap%0d.", gap_of(i));
    check_val({p, "XferBusOut"}, xo, m_xout[i]);
    check_val({p, "XferBusOE"},  16'(xe), 16'(m_xoe[i]));
    check_val({p, "MainBusOut"}, 16'(mo), 16'(m_mout[i]));
    check_val({p, "MainBusOE"},  16'(me), 16'(m_moe[i]));
    check_val({p, "busy"},       16'(bz), 16'(m_busy[i]));
    check_val({p, "done"},       16'(dn), 16'(m_done[i]));
  endtask

  // Apply inputs, clock once, advance the model and compare both instances.
  task automatic step(input logic r, input logic [15:0] v, input logic xa,
                      input logic sp, input logic ha, input logic la, input logic lo);
    t_rst = r; t_regin = v; t_xa = xa; t_split = sp; t_ha = ha; t_la = la; t_lo = lo;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_inst(0, bus0.XferBusOut, bus0.XferBusOE, bus0.MainBusOut, bus0.MainBusOE, bus0.busy, bus0.done);
    check_inst(1, bus1.XferBusOut, bus1.XferBusOE, bus1.MainBusOut, bus1.MainBusOE, bus1.busy, bus1.done);
  endtask

  task automatic idle(input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) step(1'b0, v, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    t_rst = 1'b1; t_regin = 16'd0; t_xa = 1'b0; t_split = 1'b0;
    t_ha = 1'b0; t_la = 1'b0; t_lo = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1; m_snap[i] = 16'd0; m_xout[i] = 16'd0; m_xoe[i] = 1'b0;
      m_mout[i] = 8'd0; m_moe[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0;
    end
    @(negedge clk);

    // Reset held two cycles with every control low.
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst.MainBusOE", 16'(bus0.MainBusOE), 16'd0);
    check_val("rst.XferBusOut", bus1.XferBusOut, 16'd0);
    idle(16'h0000, 1);

    // Transfer assert with concurrent low-byte assert.
    step(1'b0, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("xfer.XferBusOut", bus0.XferBusOut, 16'hBEEF);
    check_val("xfer.MainBusOut", 16'(bus0.MainBusOut), 16'h00EF);
    idle(16'hBEEF, 2);

    // Split with snapshot: RegIn changes after the start edge.
    step(1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("split.hi", 16'(bus0.MainBusOut), 16'h0012);
    step(1'b0, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("split0.lo", 16'(bus0.MainBusOut), 16'h0034);
    check_val("split0.done", 16'(bus0.done), 16'd1);
    idle(16'hABCD, 4);

    // Gap split.
    step(1'b0, 16'hA55A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(16'h0000, 3);
    check_val("gap2.lo", 16'(bus1.MainBusOut), 16'h005A);
    check_val("gap2.done", 16'(bus1.done), 16'd1);
    idle(16'h0000, 2);

    // Back-to-back splits while split request is held low.
    step(1'b0, 16'h0102, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0304, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0304, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("b2b.restart", 16'(bus0.MainBusOut), 16'h0003);
    step(1'b0, 16'h0304, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(16'h0000, 6);

    // High assert while busy is ignored.
    step(1'b0, 16'h7788, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h99AA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h99AA, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(16'h0000, 4);

    // Reset at the LOW edge of a gap-0 split, then a normal split.
    step(1'b0, 16'hFF00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 16'hFF00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_val("rstmid.done", 16'(bus0.done), 16'd0);
    check_val("rstmid.oe", 16'(bus0.MainBusOE), 16'd0);
    step(1'b0, 16'h5AA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(16'h0000, 5);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 59) == 0), 16'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
           1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
